// File: rtl/m68k_region_decoder_if.sv
// Bus and configuration signals between a 68000 CPU model (master) and the
// region decoder (slave).
interface m68k_region_decoder_if #(
  parameter int N_REGIONS = 32,
  parameter int ADDR_W    = 20,
  parameter int WAIT_W    = 4
);
  localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  logic [23:0]          a;
  logic                 as_n;
  logic                 rw;
  logic                 cfg_we;
  logic [IDX_W-1:0]     cfg_idx;
  logic                 cfg_en;
  logic [ADDR_W-1:0]    cfg_base;
  logic [ADDR_W-1:0]    cfg_mask;
  logic [WAIT_W-1:0]    cfg_wait;
  logic [1:0]           cfg_rwq;
  logic [N_REGIONS-1:0] cs;
  logic                 dtack_n;
  logic                 berr_n;
  logic                 busy;

  modport master (
    output a, as_n, rw, cfg_we, cfg_idx, cfg_en, cfg_base, cfg_mask, cfg_wait, cfg_rwq,
    input  cs, dtack_n, berr_n, busy
  );

  modport slave (
    input  a, as_n, rw, cfg_we, cfg_idx, cfg_en, cfg_base, cfg_mask, cfg_wait, cfg_rwq,
    output cs, dtack_n, berr_n, busy
  );
endinterface

// File: rtl/m68k_region_decoder.sv
// Runtime-programmable 68000 region decoder: registered one-hot chip select,
// per-region wait states, optional unmapped-access bus error (DECODER_BERR_EN).
module m68k_region_decoder #(
  parameter int N_REGIONS = 32,
  parameter int ADDR_W    = 20,
  parameter int WAIT_W    = 4,
  parameter int TIMEOUT   = 64
) (
  input logic clk,
  input logic reset,
  m68k_region_decoder_if.slave bus
);
  localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_UNMAP, ST_ERR} state_t;

  state_t               state_reg;
  logic [N_REGIONS-1:0] en_reg;
  logic [ADDR_W-1:0]    base_reg [N_REGIONS];
  logic [ADDR_W-1:0]    mask_reg [N_REGIONS];
  logic [WAIT_W-1:0]    wait_reg [N_REGIONS];
  logic [1:0]           rwq_reg  [N_REGIONS];

  logic [N_REGIONS-1:0] hit_vec;
  logic [N_REGIONS-1:0] cs_next;
  logic [WAIT_W-1:0]    wait_next;
  logic                 any_hit;

  logic [N_REGIONS-1:0] cs_reg;
  logic [WAIT_W-1:0]    wait_cnt_reg;
  logic                 dtack_n_reg;

  logic [ADDR_W-1:0]    a_dec;
  logic                 unused_a;

  assign a_dec    = bus.a[ADDR_W-1:0];
  assign unused_a = ^bus.a;

  // Only in-range indices ever match, so out-of-range writes fall through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_reg <= '0;
    end else if (bus.cfg_we) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (bus.cfg_idx == IDX_W'(i)) en_reg[i] <= bus.cfg_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      for (int i = 0; i < N_REGIONS; i++) begin
        if (bus.cfg_idx == IDX_W'(i)) begin
          base_reg[i] <= bus.cfg_base;
          mask_reg[i] <= bus.cfg_mask;
          wait_reg[i] <= bus.cfg_wait;
          rwq_reg[i]  <= bus.cfg_rwq;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_hit
    logic rwq_ok;
    assign rwq_ok = (rwq_reg[gi] == 2'b00)
                  | ((rwq_reg[gi] == 2'b01) & bus.rw)
                  | ((rwq_reg[gi] == 2'b10) & ~bus.rw);
    assign hit_vec[gi] = en_reg[gi] & rwq_ok
                       & ((a_dec & mask_reg[gi]) == (base_reg[gi] & mask_reg[gi]));
  end

  // Scan downward so the lowest-index hit is the one that sticks.
  always_comb begin
    cs_next   = '0;
    wait_next = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        cs_next    = '0;
        cs_next[i] = 1'b1;
        wait_next  = wait_reg[i];
      end
    end
  end

  assign any_hit = |hit_vec;

`ifdef DECODER_BERR_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] tcnt_reg;
  logic              berr_n_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cs_reg       <= '0;
      wait_cnt_reg <= '0;
      dtack_n_reg  <= 1'b1;
`ifdef DECODER_BERR_EN
      tcnt_reg     <= '0;
      berr_n_reg   <= 1'b1;
`endif
    end else if (state_reg != ST_IDLE && bus.as_n) begin
      // Strobe released: completes a normal cycle or aborts a pending one.
      state_reg   <= ST_IDLE;
      cs_reg      <= '0;
      dtack_n_reg <= 1'b1;
`ifdef DECODER_BERR_EN
      berr_n_reg  <= 1'b1;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!bus.as_n) begin
            cs_reg       <= cs_next;
            wait_cnt_reg <= wait_next;
            state_reg    <= any_hit ? ST_WAIT : ST_UNMAP;
`ifdef DECODER_BERR_EN
            tcnt_reg     <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg   <= ST_ACK;
            dtack_n_reg <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        ST_UNMAP: begin
`ifdef DECODER_BERR_EN
          if (tcnt_reg == TCNT_W'(TIMEOUT - 1)) begin
            state_reg  <= ST_ERR;
            berr_n_reg <= 1'b0;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
`else
          state_reg   <= ST_ACK;
          dtack_n_reg <= 1'b0;
`endif
        end
        default: begin
          state_reg <= state_reg;
        end
      endcase
    end
  end

  assign bus.cs      = cs_reg;
  assign bus.dtack_n = dtack_n_reg;
  assign bus.busy    = (state_reg != ST_IDLE);
`ifdef DECODER_BERR_EN
  assign bus.berr_n  = berr_n_reg;
`else
  assign bus.berr_n  = 1'b1;
`endif

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Directed bench for m68k_region_decoder: table of accesses plus abort,
// reset-in-ACK and same-edge reconfiguration sequences.
module tb_m68k_region_decoder;
  localparam int N_REGIONS = 32;
  localparam int ADDR_W    = 20;
  localparam int WAIT_W    = 4;
  localparam int TIMEOUT   = 64;
`ifdef DECODER_BERR_EN
  localparam int         UNMAP_LAT = TIMEOUT;
  localparam logic [1:0] UNM_STROBE = 2'b10;  // {dtack_n, berr_n}
`else
  localparam int         UNMAP_LAT = 1;
  localparam logic [1:0] UNM_STROBE = 2'b01;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  m68k_region_decoder_if #(.N_REGIONS(N_REGIONS), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W)) bus ();

  m68k_region_decoder #(
    .N_REGIONS(N_REGIONS), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic        rw;
    logic [31:0] exp_cs;
    logic        unm;
    int          lat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input logic en, input logic [19:0] base,
                           input logic [19:0] mask, input logic [3:0] w, input logic [1:0] rwq);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 5'(idx);
    bus.cfg_en   = en;
    bus.cfg_base = base;
    bus.cfg_mask = mask;
    bus.cfg_wait = w;
    bus.cfg_rwq  = rwq;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic run_access(input string tag, input logic [23:0] addr, input logic rw_v,
                            input logic [31:0] exp_cs, input logic unm, input int lat);
    int k;
    bit seen;
    @(negedge clk);
    bus.a    = addr;
    bus.rw   = rw_v;
    bus.as_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " cs_after_E0"}, bus.cs, exp_cs);
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (!bus.dtack_n || !bus.berr_n) seen = 1'b1;
    end
    check({tag, " strobe_latency"}, 32'(k), 32'(lat));
    check({tag, " strobe_kind"}, 32'({bus.dtack_n, bus.berr_n}), 32'(unm ? UNM_STROBE : 2'b01));
    check({tag, " cs_at_strobe"}, bus.cs, exp_cs);
    bus.as_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " release_cs"}, bus.cs, 32'd0);
    check({tag, " release_strobes"}, 32'({bus.busy, bus.dtack_n, bus.berr_n}), 32'(3'b011));
    $display("%s a=%06h rw=%0d cs=%08h lat=%0d", tag, addr, rw_v, exp_cs, k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want $finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.a = '0; bus.as_n = 1'b1; bus.rw = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_en = 1'b0;
    bus.cfg_base = '0; bus.cfg_mask = '0; bus.cfg_wait = '0; bus.cfg_rwq = '0;

    vecs[0]  = '{24'h007FFE, 1'b1, 32'h0000_0001, 1'b0, 1};
    vecs[1]  = '{24'h000000, 1'b0, 32'h0000_0001, 1'b0, 1};
    vecs[2]  = '{24'h008000, 1'b1, 32'h0000_0000, 1'b1, UNMAP_LAT};
    vecs[3]  = '{24'h088010, 1'b1, 32'h0000_0008, 1'b0, 4};
    vecs[4]  = '{24'h088810, 1'b1, 32'h0000_0020, 1'b0, 2};
    vecs[5]  = '{24'h080000, 1'b1, 32'h0000_0004, 1'b0, 3};
    vecs[6]  = '{24'h080000, 1'b0, 32'h0000_0000, 1'b1, UNMAP_LAT};
    vecs[7]  = '{24'h040010, 1'b0, 32'h0000_0080, 1'b0, 2};
    vecs[8]  = '{24'h040010, 1'b1, 32'h0000_0000, 1'b1, UNMAP_LAT};
    vecs[9]  = '{24'h050000, 1'b1, 32'h0000_0000, 1'b1, UNMAP_LAT};
    vecs[10] = '{24'h0FFFFC, 1'b1, 32'h8000_0000, 1'b0, 16};
    vecs[11] = '{24'h060000, 1'b1, 32'h0000_0000, 1'b1, UNMAP_LAT};
    vecs[12] = '{24'hF07FFE, 1'b1, 32'h0000_0001, 1'b0, 1};

    repeat (3) @(negedge clk);
    check("reset cs", bus.cs, 32'd0);
    check("reset strobes", 32'({bus.busy, bus.dtack_n, bus.berr_n}), 32'(3'b011));
    reset = 1'b0;

    cfg_write(0,  1'b1, 20'h00000, 20'hF8000, 4'd0,  2'b00);
    cfg_write(3,  1'b1, 20'h88000, 20'hFF800, 4'd3,  2'b00);
    cfg_write(5,  1'b1, 20'h88000, 20'hFF000, 4'd1,  2'b00);
    cfg_write(2,  1'b1, 20'h80000, 20'hFF000, 4'd2,  2'b01);
    cfg_write(7,  1'b1, 20'h40000, 20'hFF000, 4'd1,  2'b10);
    cfg_write(9,  1'b1, 20'h50000, 20'hFF000, 4'd0,  2'b11);
    cfg_write(31, 1'b1, 20'hFFFF0, 20'hFFFF0, 4'd15, 2'b00);
    cfg_write(10, 1'b0, 20'h60000, 20'hFF000, 4'd0,  2'b00);
    cfg_write(12, 1'b1, 20'h30000, 20'hFF000, 4'd7,  2'b00);

    for (int i = 0; i < 13; i++) begin
      run_access($sformatf("vec%0d", i), vecs[i].a, vecs[i].rw, vecs[i].exp_cs,
                 vecs[i].unm, vecs[i].lat);
    end

    // Abort a wait=7 cycle after two wait cycles.
    @(negedge clk);
    bus.a = 24'h030004; bus.rw = 1'b1; bus.as_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort cs_after_E0", bus.cs, 32'h0000_1000);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("abort dtack_wait", 32'(bus.dtack_n), 32'd1);
    end
    bus.as_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort cs", bus.cs, 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    repeat (8) begin
      @(negedge clk);
      check("abort dtack_never", 32'(bus.dtack_n), 32'd1);
    end
    $display("abort a=030004 cs=0 after release");

    // Reset while in ACK.
    @(negedge clk);
    bus.a = 24'h007FFE; bus.rw = 1'b1; bus.as_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_ack dtack_before", 32'(bus.dtack_n), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_ack cs", bus.cs, 32'd0);
    check("rst_ack strobes", 32'({bus.busy, bus.dtack_n, bus.berr_n}), 32'(3'b011));
    bus.as_n = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("rst_ack outputs cleared asynchronously");
    run_access("rst_after", 24'h007FFE, 1'b1, 32'd0, 1'b1, UNMAP_LAT);

    // Retarget entry 0 on the same edge that starts a cycle.
    cfg_write(0, 1'b1, 20'h00000, 20'hF8000, 4'd0, 2'b00);
    @(negedge clk);
    bus.a = 24'h007FFE; bus.rw = 1'b1; bus.as_n = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_idx = 5'd0; bus.cfg_en = 1'b1;
    bus.cfg_base = 20'h10000; bus.cfg_mask = 20'hF8000; bus.cfg_wait = 4'd0; bus.cfg_rwq = 2'b00;
    @(posedge clk);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check("retgt old_cs", bus.cs, 32'h0000_0001);
    @(posedge clk);
    @(negedge clk);
    check("retgt old_dtack", 32'(bus.dtack_n), 32'd0);
    bus.as_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("retgt old_release", 32'({bus.busy, bus.dtack_n}), 32'(2'b01));
    $display("retgt old mapping a=007FFE cs=00000001");
    run_access("retgt_oldaddr", 24'h007FFE, 1'b1, 32'd0, 1'b1, UNMAP_LAT);
    run_access("retgt_newaddr", 24'h010000, 1'b1, 32'h0000_0001, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
